// File: rtl/sobel_filter.sv
// sobel_filter: streaming 3x3 Sobel edge detector for raster-order greyscale frames.
// Two line buffers hold the previous two rows; a 3x3 register window slides along
// each row. Gx/Gy are registered, then the saturated |Gx|+|Gy| magnitude is
// registered onto pixel_out two edges after the window's bottom-right pixel.
// Optional build macro: SOBEL_THRESHOLD_EN -- binarize the magnitude against THRESHOLD.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_ARM    | one dead cycle, pixel_in not sampled, counters cleared
// S_STREAM | sampling IMG_WIDTH*IMG_HEIGHT pixels in raster order
// S_FLUSH  | draining the Gx/Gy and magnitude stages
// S_DONE   | frame complete, done held until the next start
module sobel_filter #(
  parameter int WIDTH      = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int THRESHOLD  = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pixel_in,
  output logic [WIDTH-1:0] pixel_out,
  output logic             valid_out,
  output logic             done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int SW = WIDTH + 4;
  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [WIDTH-1:0] PIX_MAX  = '1;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            r_done;

  logic [WIDTH-1:0] r_lb1 [IMG_WIDTH];
  logic [WIDTH-1:0] r_lb2 [IMG_WIDTH];

  logic [WIDTH-1:0] r_w00, r_w01, r_w02;
  logic [WIDTH-1:0] r_w10, r_w11, r_w12;
  logic [WIDTH-1:0] r_w20, r_w21, r_w22;

  logic                 r_win_vld;
  logic                 r_s1_vld;
  logic signed [SW-1:0] r_gx, r_gy;
  logic                 r_valid_out;
  logic [WIDTH-1:0]     r_pixel_out;

  logic                 w_sample;
  logic signed [SW-1:0] w_gx, w_gy;
  logic [SW-1:0]        w_abs_gx, w_abs_gy, w_mag;
  logic [WIDTH-1:0]     w_result;

  function automatic logic signed [SW-1:0] ext(input logic [WIDTH-1:0] p);
    return signed'({{(SW-WIDTH){1'b0}}, p});
  endfunction

  assign w_sample = (r_state == S_STREAM);

  // Frame sequencing and raster position of the pixel being sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_ARM;
        end
        S_ARM: begin
          r_col   <= '0;
          r_row   <= '0;
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (r_col == COL_LAST) begin
            r_col <= '0;
            if (r_row == ROW_LAST) begin
              r_row   <= '0;
              r_state <= S_FLUSH;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_FLUSH: begin
          // Final output is on the port this cycle and nothing is left behind it.
          if (r_valid_out && !r_s1_vld && !r_win_vld) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            r_state <= S_ARM;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line buffers and 3x3 window shift; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_sample) begin
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= pixel_in;
      r_w00 <= r_w01;  r_w01 <= r_w02;  r_w02 <= r_lb2[r_col];
      r_w10 <= r_w11;  r_w11 <= r_w12;  r_w12 <= r_lb1[r_col];
      r_w20 <= r_w21;  r_w21 <= r_w22;  r_w22 <= pixel_in;
    end
  end

  // Sobel kernels over the current window (right minus left, bottom minus top).
  always_comb begin
    w_gx = (ext(r_w02) + (ext(r_w12) <<< 1) + ext(r_w22))
         - (ext(r_w00) + (ext(r_w10) <<< 1) + ext(r_w20));
    w_gy = (ext(r_w20) + (ext(r_w21) <<< 1) + ext(r_w22))
         - (ext(r_w00) + (ext(r_w01) <<< 1) + ext(r_w02));
  end

  // Gradient pipeline stage; data is qualified by r_s1_vld so needs no reset.
  always_ff @(posedge clk) begin
    r_gx <= w_gx;
    r_gy <= w_gy;
  end

  // Magnitude with saturation, or binarized magnitude when thresholding is built in.
  always_comb begin
    w_abs_gx = r_gx[SW-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
    w_abs_gy = r_gy[SW-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
    w_mag    = w_abs_gx + w_abs_gy;
`ifdef SOBEL_THRESHOLD_EN
    w_result = (w_mag > SW'(THRESHOLD)) ? PIX_MAX : '0;
`else
    w_result = (|w_mag[SW-1:WIDTH]) ? PIX_MAX : w_mag[WIDTH-1:0];
`endif
  end

  // Valid pipeline: window valid only once two full rows and two columns are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_vld   <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_valid_out <= 1'b0;
      r_pixel_out <= '0;
    end else begin
      r_win_vld   <= w_sample && (r_row >= RW'(2)) && (r_col >= CW'(2));
      r_s1_vld    <= r_win_vld;
      r_valid_out <= r_s1_vld;
      if (r_s1_vld) r_pixel_out <= w_result;
    end
  end

  assign pixel_out = r_pixel_out;
  assign valid_out = r_valid_out;
  assign done      = r_done;

endmodule

// File: tb/tb_sobel_filter.sv
// Scoreboard bench for sobel_filter: stimulus pushes {value, cycle} expectations
// computed from a reference convolution of the frame; a monitor pops on valid_out.
module tb_sobel_filter;
  localparam int W   = 64;
  localparam int H   = 64;
  localparam int THR = 128;
  localparam int NOUT = (W-2)*(H-2);

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pixel_in;
  logic [7:0] pixel_out;
  logic       valid_out;
  logic       done;

  always #5 clk = ~clk;

  sobel_filter #(.WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(THR)) dut (
    .clk(clk), .rst(rst), .start(start), .pixel_in(pixel_in),
    .pixel_out(pixel_out), .valid_out(valid_out), .done(done)
  );

  typedef struct { int val; int cyc; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_count = 0;
  int last_valid_cyc = -10;
  logic prev_done = 1'b0;
  int pix [H][W];

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Monitor: compare each output's value and arrival cycle against the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst !== 1'b0) begin
      prev_done = 1'b0;
    end else begin
      if (valid_out) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got pixel_out=%0d at cycle %0d, required no output",
                   pixel_out, cyc);
        end else begin
          e = sb.pop_front();
          if (pixel_out !== 8'(e.val) || cyc != e.cyc) begin
            errors++;
            $display("FAIL out_pixel: got %0d at cycle %0d, required %0d at cycle %0d",
                     pixel_out, cyc, e.val, e.cyc);
          end
        end
        out_count++;
        last_valid_cyc = cyc;
      end
      if (done && !prev_done) check("done_rise_cycle", cyc, last_valid_cyc + 1);
      prev_done = done;
    end
  end

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: pix[r][c] = 100;
          1: pix[r][c] = (c < 32) ? 0 : 255;
          default: pix[r][c] = (r + c) * 2;
        endcase
  endtask

  function automatic int model(input int r, input int c);
    int gx, gy, m;
    gx = (pix[r-2][c] + 2*pix[r-1][c] + pix[r][c])
       - (pix[r-2][c-2] + 2*pix[r-1][c-2] + pix[r][c-2]);
    gy = (pix[r][c-2] + 2*pix[r][c-1] + pix[r][c])
       - (pix[r-2][c-2] + 2*pix[r-2][c-1] + pix[r-2][c]);
    m = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
    return (m > THR) ? 255 : 0;
`else
    return (m > 255) ? 255 : m;
`endif
  endfunction

  // abort_at >= 0: assert reset before that pixel; start_at >= 0: stray start pulse there.
  task automatic run_frame(input int abort_at, input int start_at);
    int base;
    logic was_done;
    base = out_count;
    was_done = done;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (was_done) check("done_clear_on_start", int'(done), 0);
    @(negedge clk);
    for (int i = 0; i < W*H; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      if (i == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("abort_valid_out", int'(valid_out), 0);
        check("abort_done", int'(done), 0);
        check("abort_pixel_out", int'(pixel_out), 0);
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        return;
      end
      pixel_in = 8'(pix[r][c]);
      start = (i == start_at);
      if (r >= 2 && c >= 2) sb.push_back('{model(r, c), cyc + 3});
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    check("done_set", int'(done), 1);
    check("frame_output_count", out_count - base, NOUT);
    check("scoreboard_drained", sb.size(), 0);
    repeat (5) @(negedge clk);
    check("done_sticky", int'(done), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, required finish before 1000000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pixel_in = '0;
    repeat (3) @(negedge clk);
    check("reset_pixel_out", int'(pixel_out), 0);
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_done", int'(done), 0);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_done", int'(done), 0);

    fill(0); run_frame(-1, -1);
    fill(1); run_frame(-1, -1);
    fill(2); run_frame(-1, -1);

    fill(0); run_frame(2000, -1);
    repeat (10) @(negedge clk);
    check("post_abort_done", int'(done), 0);
    run_frame(-1, -1);

    fill(2); run_frame(-1, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
